// File: rtl/tpu_pkg.sv
// ============================================================================
// tpu_pkg : shared types and constants for the 2x2 matmul sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

    localparam int unsigned NUM_OPERANDS = 8;
    localparam int unsigned COMPUTE_LEN  = 5;
    localparam int unsigned NUM_RESULTS  = 4;

    localparam logic [3:0] LD_CNT_MAX = 4'(NUM_OPERANDS);
    localparam logic [3:0] CC_LAST    = 4'(COMPUTE_LEN);
    localparam logic [1:0] RES_LAST   = 2'(NUM_RESULTS - 1);

    // Operand memory map: weights first, then inputs.
    localparam logic [2:0] W_BASE = 3'd0;
    localparam logic [2:0] X_BASE = 3'd4;

    function automatic logic [3:0] ld_cnt_sat_inc(input logic [3:0] cnt);
        return (cnt >= LD_CNT_MAX) ? cnt : cnt + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_sequencer_if.sv
// ============================================================================
// tpu_sequencer_if : host, operand-memory and feeder signals of the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tpu_sequencer_if;

    logic       abort;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       feeder_en;
    logic [3:0] compute_cycles;
    logic [1:0] output_sel;
    logic       feeder_done;
    logic       out_valid;
    logic       out_ack;
    logic       busy;
    logic       seq_err;

    modport slave (
        input  abort, load_valid, load_data, feeder_done, out_ack,
        output load_ready, mem_we, mem_addr, mem_wdata, feeder_en,
               compute_cycles, output_sel, out_valid, busy, seq_err
    );

    modport master (
        output abort, load_valid, load_data, feeder_done, out_ack,
        input  load_ready, mem_we, mem_addr, mem_wdata, feeder_en,
               compute_cycles, output_sel, out_valid, busy, seq_err
    );

endinterface

`default_nettype wire

// File: rtl/tpu_sequencer.sv
// ============================================================================
// tpu_sequencer : load -> compute -> output control FSM for the 2x2 matmul
// Revision: 1.0
// ============================================================================
`default_nettype none

module tpu_sequencer
    import tpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    tpu_sequencer_if.slave  bus
);

    state_e     state_q;
    logic [3:0] ld_cnt_q;
    logic [3:0] cc_q;
    logic [1:0] res_idx_q;
    logic       load_ready_q;
    logic       mem_we_q;
    logic [2:0] mem_addr_q;
    logic [7:0] mem_wdata_q;
    logic       feeder_en_q;
    logic       out_valid_q;
    logic       seq_err_q;

    logic       load_fire;
    logic [3:0] ld_cnt_d;

    assign load_fire = bus.load_valid && load_ready_q;
    assign ld_cnt_d  = ld_cnt_sat_inc(ld_cnt_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ld_cnt_q     <= 4'd0;
            cc_q         <= 4'd0;
            res_idx_q    <= 2'd0;
            load_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 3'd0;
            mem_wdata_q  <= 8'd0;
            feeder_en_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            seq_err_q    <= 1'b0;
        end else if (bus.abort) begin
            // seq_err is deliberately kept: it reports the last finished pass.
            state_q      <= ST_IDLE;
            ld_cnt_q     <= 4'd0;
            cc_q         <= 4'd0;
            res_idx_q    <= 2'd0;
            load_ready_q <= 1'b1;
            mem_we_q     <= 1'b0;
            feeder_en_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            mem_we_q <= load_fire;
            if (load_fire) begin
                mem_addr_q   <= W_BASE + ld_cnt_q[2:0];
                mem_wdata_q  <= bus.load_data;
                ld_cnt_q     <= ld_cnt_d;
                load_ready_q <= (ld_cnt_d < LD_CNT_MAX);
            end

            case (state_q)
                ST_IDLE: begin
                    feeder_en_q  <= 1'b0;
                    load_ready_q <= 1'b1;
                    if (load_fire) begin
                        state_q   <= ST_LOAD;
                        seq_err_q <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    // Waiting one cycle at full count lets the last write land first.
                    if (!load_fire && (ld_cnt_q == LD_CNT_MAX)) begin
                        state_q     <= ST_COMPUTE;
                        feeder_en_q <= 1'b1;
                        cc_q        <= 4'd0;
                    end
                end

                ST_COMPUTE: begin
                    if (cc_q == CC_LAST) begin
                        if (!bus.feeder_done) begin
                            seq_err_q <= 1'b1;
                        end
                        state_q     <= ST_OUTPUT;
                        out_valid_q <= 1'b1;
                        res_idx_q   <= 2'd0;
                    end else begin
                        cc_q <= cc_q + 4'd1;
                    end
                end

                ST_OUTPUT: begin
                    if (bus.out_ack && out_valid_q) begin
                        if (res_idx_q == RES_LAST) begin
                            state_q      <= ST_IDLE;
                            feeder_en_q  <= 1'b0;
                            out_valid_q  <= 1'b0;
                            res_idx_q    <= 2'd0;
                            cc_q         <= 4'd0;
                            ld_cnt_q     <= 4'd0;
                            load_ready_q <= 1'b1;
                        end else begin
                            res_idx_q <= res_idx_q + 2'd1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready     = load_ready_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.feeder_en      = feeder_en_q;
    assign bus.compute_cycles = cc_q;
    assign bus.output_sel     = res_idx_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.seq_err        = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tpu_sequencer.sv
// ============================================================================
// tb_tpu_sequencer : directed jobs checked against a job-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tpu_sequencer;
    import tpu_pkg::*;

    localparam int N_OPS = int'(NUM_OPERANDS);
    localparam int CLEN  = int'(COMPUTE_LEN);
    localparam int N_RES = int'(NUM_RESULTS);
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COMPUTE = 2, PH_OUTPUT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic force_low;
    always #5 clk = ~clk;

    tpu_sequencer_if bus();

    // Feeder stand-in: done from step 2 onward, optionally dropped at the last step.
    assign bus.feeder_done = bus.feeder_en && (bus.compute_cycles >= 4'd2)
                             && !(force_low && (bus.compute_cycles == 4'd5));

    tpu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job data and expected results.
    logic [7:0] job [8];
    int         exp_c [4];
    int         lit_res [4] = '{19, 22, 43, 50};
    bit         lit_job;
    bit         chk_en;

    task automatic set_job(input logic [63:0] v);
        for (int k = 0; k < 8; k++) job[k] = v[63 - 8*k -: 8];
        for (int s = 0; s < 4; s++) begin
            exp_c[s] = 0;
            for (int k = 0; k < 2; k++)
                exp_c[s] += int'(job[2*(s/2) + k]) * int'(job[4 + 2*k + (s%2)]);
        end
    endtask

    // Operand memory as written by the DUT; results are the matmul over it.
    logic [7:0] tbmem [8];
    always @(posedge clk) if (bus.mem_we) tbmem[bus.mem_addr] <= bus.mem_wdata;

    function automatic int fres(input logic [1:0] sel);
        int acc = 0;
        for (int k = 0; k < 2; k++)
            acc += int'(tbmem[int'(W_BASE) + 2*int'(sel[1]) + k])
                 * int'(tbmem[int'(X_BASE) + 2*k + int'(sel[0])]);
        return acc;
    endfunction

    // Reference model: job phase, operand count, compute step, result index.
    int m_phase, m_nload, m_step, m_res, m_addr, m_data;
    bit m_err, m_fresh, m_we;
    int cyc = 0;
    int last_acc_cyc = 0;

    function automatic int e_ready();
        return (!m_fresh && (m_phase == PH_IDLE ||
               (m_phase == PH_LOAD && m_nload < N_OPS))) ? 1 : 0;
    endfunction
    function automatic int e_cc();
        return (m_phase == PH_COMPUTE) ? m_step : (m_phase == PH_OUTPUT) ? CLEN : 0;
    endfunction

    always @(posedge clk) begin : p_model
        bit acc;
        acc = bus.load_valid && (e_ready() == 1);
        if (!rst_n) begin
            m_phase = PH_IDLE; m_nload = 0; m_step = 0; m_res = 0;
            m_err = 1'b0; m_fresh = 1'b1; m_we = 1'b0; m_addr = 0; m_data = 0;
        end else begin
            m_fresh = 1'b0;
            if (bus.abort) begin
                m_phase = PH_IDLE; m_nload = 0; m_step = 0; m_res = 0; m_we = 1'b0;
            end else begin
                m_we = acc;
                if (acc) begin
                    m_addr = m_nload;
                    m_data = int'(bus.load_data);
                    if (m_nload == N_OPS - 1) last_acc_cyc = cyc;
                    if (m_nload < N_OPS) m_nload++;
                    if (m_phase == PH_IDLE) begin
                        m_phase = PH_LOAD;
                        m_err   = 1'b0;
                    end
                end else if (m_phase == PH_LOAD && m_nload == N_OPS) begin
                    m_phase = PH_COMPUTE; m_step = 0;
                end else if (m_phase == PH_COMPUTE) begin
                    if (m_step == CLEN) begin
                        if (!bus.feeder_done) m_err = 1'b1;
                        m_phase = PH_OUTPUT; m_res = 0;
                    end else begin
                        m_step++;
                    end
                end else if (m_phase == PH_OUTPUT && bus.out_ack) begin
                    if (m_res == N_RES - 1) begin
                        m_phase = PH_IDLE; m_nload = 0; m_res = 0;
                    end else begin
                        m_res++;
                    end
                end
            end
        end
        cyc++;
    end

    bit ov_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",           int'(bus.busy),           (m_phase != PH_IDLE) ? 1 : 0);
            chk("load_ready",     int'(bus.load_ready),     e_ready());
            chk("mem_we",         int'(bus.mem_we),         int'(m_we));
            chk("feeder_en",      int'(bus.feeder_en),      (m_phase >= PH_COMPUTE) ? 1 : 0);
            chk("compute_cycles", int'(bus.compute_cycles), e_cc());
            chk("output_sel",     int'(bus.output_sel),     (m_phase == PH_OUTPUT) ? m_res : 0);
            chk("out_valid",      int'(bus.out_valid),      (m_phase == PH_OUTPUT) ? 1 : 0);
            chk("seq_err",        int'(bus.seq_err),        int'(m_err));
            if (m_we) begin
                chk("mem_addr",  int'(bus.mem_addr),  m_addr);
                chk("mem_wdata", int'(bus.mem_wdata), m_data);
            end
            if (m_phase == PH_OUTPUT && bus.out_valid) begin
                chk("result", fres(bus.output_sel), exp_c[m_res]);
                if (lit_job) chk("result_literal", fres(bus.output_sel), lit_res[m_res]);
            end
            if (bus.out_valid && !ov_prev)
                chk("accept_to_valid_latency", cyc - last_acc_cyc, 8);
            ov_prev = bus.out_valid;
        end
    end

    // Stimulus helpers; all are entered and left just after a falling edge.
    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        while (!bus.load_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("load_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic load_range(input int lo, input int hi, input bit gapped);
        for (int k = lo; k < hi; k++) begin
            push_byte(job[k]);
            if (gapped) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'hEE;
                @(negedge clk);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic ack_all(input int stall);
        wait_ov();
        repeat (stall) @(negedge clk);
        if (stall > 0) begin
            chk("stall_sel",   int'(bus.output_sel), 0);
            chk("stall_valid", int'(bus.out_valid),  1);
            chk("stall_en",    int'(bus.feeder_en),  1);
        end
        repeat (N_RES) begin
            bus.out_ack = 1'b1;
            @(negedge clk);
        end
        bus.out_ack = 1'b0;
        chk("idle_after_acks",  int'(bus.busy),      0);
        chk("valid_after_acks", int'(bus.out_valid), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; force_low = 1'b0; chk_en = 1'b0; lit_job = 1'b0;
        bus.abort = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00; bus.out_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy",       int'(bus.busy),           0);
        chk("rst_load_ready", int'(bus.load_ready),     0);
        chk("rst_mem_addr",   int'(bus.mem_addr),       0);
        chk("rst_mem_wdata",  int'(bus.mem_wdata),      0);
        chk("rst_cc",         int'(bus.compute_cycles), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(bus.load_ready), 1);

        // Full back-to-back job with the reference operands.
        set_job(64'h01020304_05060708);
        lit_job = 1'b1;
        load_range(0, 8, 1'b0);
        ack_all(0);
        lit_job = 1'b0;

        // Gapped load.
        set_job(64'h02000103_04010002);
        load_range(0, 8, 1'b1);
        ack_all(0);

        // Host stall in OUTPUT.
        set_job(64'h01020304_05060708);
        load_range(0, 8, 1'b0);
        ack_all(20);

        // Abort mid-LOAD with a byte presented.
        set_job(64'h03010204_01030201);
        load_range(0, 3, 1'b0);
        bus.load_valid = 1'b1; bus.load_data = 8'hAA; bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.load_valid = 1'b0;
        chk("abort_load_busy",   int'(bus.busy),      0);
        chk("abort_load_mem_we", int'(bus.mem_we),    0);
        chk("abort_load_en",     int'(bus.feeder_en), 0);

        // Abort mid-COMPUTE at step 2.
        load_range(0, 8, 1'b0);
        n = 0;
        while (!(bus.feeder_en && bus.compute_cycles == 4'd2) && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) chk("compute_step2_timeout", 0, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_comp_en",   int'(bus.feeder_en),      0);
        chk("abort_comp_busy", int'(bus.busy),           0);
        chk("abort_comp_cc",   int'(bus.compute_cycles), 0);

        // Fresh job after the aborts must restart at address 0.
        set_job(64'h05040302_01020304);
        load_range(0, 8, 1'b0);
        ack_all(0);

        // Abort in OUTPUT together with an ack.
        set_job(64'h01020304_05060708);
        load_range(0, 8, 1'b0);
        wait_ov();
        bus.abort = 1'b1; bus.out_ack = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.out_ack = 1'b0;
        chk("abort_out_valid", int'(bus.out_valid),  0);
        chk("abort_out_sel",   int'(bus.output_sel), 0);

        // Missing feeder_done at the last step.
        force_low = 1'b1;
        set_job(64'h02000103_04010002);
        load_range(0, 8, 1'b0);
        wait_ov();
        chk("seq_err_set", int'(bus.seq_err), 1);
        ack_all(0);
        chk("seq_err_sticky", int'(bus.seq_err), 1);
        force_low = 1'b0;
        set_job(64'h01020304_05060708);
        load_range(0, 1, 1'b0);
        chk("seq_err_cleared", int'(bus.seq_err), 0);
        load_range(1, 8, 1'b0);
        ack_all(0);

        // Reset during OUTPUT at result index 2.
        set_job(64'h05040302_01020304);
        load_range(0, 8, 1'b0);
        wait_ov();
        bus.out_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ack = 1'b0;
        chk("sel_before_reset", int'(bus.output_sel), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_busy",  int'(bus.busy),           0);
        chk("rst_out_valid", int'(bus.out_valid),      0);
        chk("rst_out_en",    int'(bus.feeder_en),      0);
        chk("rst_out_sel",   int'(bus.output_sel),     0);
        chk("rst_out_cc",    int'(bus.compute_cycles), 0);
        chk("rst_out_ready", int'(bus.load_ready),     0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(bus.load_ready), 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
